// File: rtl/alu_writeback_pkg.sv
// Shared types and constants for the ALU write-back stage: widths,
// privilege encodings and the buffered result entry.
package alu_writeback_pkg;

  localparam int XLEN   = 64;
  localparam int ITAG_W = 8;
  localparam int DEPTH  = 2;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef struct packed {
    logic [ITAG_W-1:0] itag;
    logic [XLEN-1:0]   pc;
    logic [1:0]        priv;
    logic [4:0]        rd;
    logic [11:0]       csr;
    logic              gprwe;
    logic              csrwe;
    logic [XLEN-1:0]   data1;
    logic [XLEN-1:0]   data2;
  } wb_entry_t;

  // CSR address bits [9:8] encode the lowest privilege allowed to access it.
  function automatic logic csr_priv_ok(input logic [1:0] priv, input logic [1:0] csr_lvl);
    return priv >= csr_lvl;
  endfunction

endpackage

// File: rtl/alu_writeback_wb_fifo2.sv
// Two-entry circular result buffer with 1-bit pointers and a 2-bit count;
// the head entry is visible combinationally.
module wb_fifo2
  import alu_writeback_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      flush_i,
  input  logic      push_valid_i,
  input  wb_entry_t push_entry_i,
  input  logic      pop_i,
  output logic      ready_o,
  output logic      head_valid_o,
  output wb_entry_t head_o
);

  wb_entry_t  mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       push;
  logic       pop;

  assign ready_o      = (count_q != 2'd2) && !flush_i;
  assign head_valid_o = (count_q != 2'd0);
  assign head_o       = mem_q[rd_ptr_q];
  assign push         = push_valid_i & ready_o;
  assign pop          = pop_i & head_valid_o & ~flush_i;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// Write-back stage: commits buffered ALU results in order to the GPR and CSR
// write ports, checks CSR privilege, counts retirements and itag ordering.
module alu_writeback
  import alu_writeback_pkg::*;
(
  input  logic              WBi_CLK,
  input  logic              WBi_ARST,
  input  logic              WBi_Flush,
  input  logic              PIP_WBi_MSC_valid,
  input  logic [ITAG_W-1:0] PIP_WBi_INFO_itag,
  input  logic [XLEN-1:0]   PIP_WBi_INFO_pc,
  input  logic [1:0]        PIP_WBi_INFO_priv,
  input  logic [4:0]        PIP_WBi_INFO_rd,
  input  logic [11:0]       PIP_WBi_INFO_csr,
  input  logic              PIP_WBi_INFO_gprwe,
  input  logic              PIP_WBi_INFO_csrwe,
  input  logic [XLEN-1:0]   PIP_WBi_DATA_data1,
  input  logic [XLEN-1:0]   PIP_WBi_DATA_data2,
  output logic              PIP_WBo_FC_ready,
  output logic              GPR_WBo_we,
  output logic [4:0]        GPR_WBo_addr,
  output logic [XLEN-1:0]   GPR_WBo_data,
  output logic              CSR_WBo_we,
  output logic [11:0]       CSR_WBo_addr,
  output logic [XLEN-1:0]   CSR_WBo_data,
  input  logic              CSR_WBi_ready,
  output logic              EXC_WBo_valid,
  output logic [ITAG_W-1:0] EXC_WBo_itag,
  output logic [XLEN-1:0]   EXC_WBo_pc,
  output logic [63:0]       WBo_retire_cnt,
  output logic              WBo_ERR_order
);

  wb_entry_t         in_entry;
  wb_entry_t         head;
  logic              head_valid;
  logic              csr_ok;
  logic              csr_req;
  logic              retire;
  logic              illegal;

  logic              exc_valid_q;
  logic [ITAG_W-1:0] exc_itag_q;
  logic [XLEN-1:0]   exc_pc_q;
  logic [63:0]       retire_cnt_q;
  logic [ITAG_W-1:0] expected_q;
  logic              sync_q;
  logic              err_q;

  assign in_entry = '{itag:  PIP_WBi_INFO_itag,  pc:    PIP_WBi_INFO_pc,
                      priv:  PIP_WBi_INFO_priv,  rd:    PIP_WBi_INFO_rd,
                      csr:   PIP_WBi_INFO_csr,   gprwe: PIP_WBi_INFO_gprwe,
                      csrwe: PIP_WBi_INFO_csrwe, data1: PIP_WBi_DATA_data1,
                      data2: PIP_WBi_DATA_data2};

  wb_fifo2 u_fifo (
    .clk_i        (WBi_CLK),
    .rst_i        (WBi_ARST),
    .flush_i      (WBi_Flush),
    .push_valid_i (PIP_WBi_MSC_valid),
    .push_entry_i (in_entry),
    .pop_i        (retire),
    .ready_o      (PIP_WBo_FC_ready),
    .head_valid_o (head_valid),
    .head_o       (head)
  );

  assign csr_ok  = csr_priv_ok(head.priv, head.csr[9:8]);
  assign csr_req = head.csrwe & csr_ok;
  assign retire  = head_valid & ~WBi_Flush & (~csr_req | CSR_WBi_ready);
  // An illegal CSR access still retires (and does its GPR write), but raises an exception.
  assign illegal = retire & head.csrwe & ~csr_ok;

  assign GPR_WBo_we   = retire & head.gprwe & (head.rd != 5'd0);
  assign GPR_WBo_addr = head.rd;
  assign GPR_WBo_data = head.data1;
  assign CSR_WBo_we   = head_valid & csr_req & ~WBi_Flush;
  assign CSR_WBo_addr = head.csr;
  assign CSR_WBo_data = head.data2;

  assign EXC_WBo_valid  = exc_valid_q;
  assign EXC_WBo_itag   = exc_itag_q;
  assign EXC_WBo_pc     = exc_pc_q;
  assign WBo_retire_cnt = retire_cnt_q;
  assign WBo_ERR_order  = err_q;

  always_ff @(posedge WBi_CLK or posedge WBi_ARST) begin
    if (WBi_ARST) begin
      exc_valid_q  <= 1'b0;
      exc_itag_q   <= '0;
      exc_pc_q     <= '0;
      retire_cnt_q <= 64'd0;
    end else begin
      exc_valid_q <= illegal;
      if (illegal) begin
        exc_itag_q <= head.itag;
        exc_pc_q   <= head.pc;
      end
      if (retire) begin
        retire_cnt_q <= retire_cnt_q + 64'd1;
      end
    end
  end

  // The first retirement after reset or flush seeds the expected itag instead of being checked.
  always_ff @(posedge WBi_CLK or posedge WBi_ARST) begin
    if (WBi_ARST) begin
      expected_q <= '0;
      sync_q     <= 1'b1;
      err_q      <= 1'b0;
    end else if (WBi_Flush) begin
      sync_q <= 1'b1;
    end else if (retire) begin
      sync_q     <= 1'b0;
      expected_q <= head.itag + ITAG_W'(1);
      if (!sync_q && (head.itag != expected_q)) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed, table-driven bench for alu_writeback with hand-computed expectations,
// plus a hand-written asynchronous-reset-during-stall sequence.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, valid, gprwe, csrwe, csr_rdy;
  logic [7:0]  itag;
  logic [63:0] pc, d1, d2;
  logic [1:0]  priv;
  logic [4:0]  rd;
  logic [11:0] csr;
  logic        ready, gpr_we, csr_we, exc_v, err;
  logic [4:0]  gpr_addr;
  logic [63:0] gpr_data, csr_data, exc_pc, cnt;
  logic [11:0] csr_addr;
  logic [7:0]  exc_itag;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_writeback dut (
    .WBi_CLK(clk), .WBi_ARST(rst), .WBi_Flush(flush),
    .PIP_WBi_MSC_valid(valid), .PIP_WBi_INFO_itag(itag), .PIP_WBi_INFO_pc(pc),
    .PIP_WBi_INFO_priv(priv), .PIP_WBi_INFO_rd(rd), .PIP_WBi_INFO_csr(csr),
    .PIP_WBi_INFO_gprwe(gprwe), .PIP_WBi_INFO_csrwe(csrwe),
    .PIP_WBi_DATA_data1(d1), .PIP_WBi_DATA_data2(d2),
    .PIP_WBo_FC_ready(ready),
    .GPR_WBo_we(gpr_we), .GPR_WBo_addr(gpr_addr), .GPR_WBo_data(gpr_data),
    .CSR_WBo_we(csr_we), .CSR_WBo_addr(csr_addr), .CSR_WBo_data(csr_data),
    .CSR_WBi_ready(csr_rdy),
    .EXC_WBo_valid(exc_v), .EXC_WBo_itag(exc_itag), .EXC_WBo_pc(exc_pc),
    .WBo_retire_cnt(cnt), .WBo_ERR_order(err)
  );

  typedef struct {
    logic        flush, valid;
    logic [7:0]  itag;
    logic [1:0]  priv;
    logic [4:0]  rd;
    logic [11:0] csr;
    logic        gprwe, csrwe;
    logic [63:0] d1, d2;
    logic        crdy;
    logic        e_rdy, e_gwe;
    logic [4:0]  e_gaddr;
    logic [63:0] e_gdata;
    logic        e_cwe;
    logic [63:0] e_cdata;
    logic        e_exc;
    logic [7:0]  e_eitag;
    logic [63:0] e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
      input logic f, input logic v, input logic [7:0] it, input logic [1:0] pv,
      input logic [4:0] r, input logic [11:0] c, input logic gw, input logic cw,
      input logic [63:0] a, input logic [63:0] b, input logic cr,
      input logic erdy, input logic egwe, input logic [4:0] ega, input logic [63:0] egd,
      input logic ecwe, input logic [63:0] ecd, input logic eexc, input logic [7:0] eeit,
      input logic [63:0] ecnt, input logic eerr);
    vec_t t;
    t.flush = f; t.valid = v; t.itag = it; t.priv = pv; t.rd = r; t.csr = c;
    t.gprwe = gw; t.csrwe = cw; t.d1 = a; t.d2 = b; t.crdy = cr;
    t.e_rdy = erdy; t.e_gwe = egwe; t.e_gaddr = ega; t.e_gdata = egd;
    t.e_cwe = ecwe; t.e_cdata = ecd; t.e_exc = eexc; t.e_eitag = eeit;
    t.e_cnt = ecnt; t.e_err = eerr;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    flush = 1'b0; valid = 1'b0; itag = 8'h00; pc = 64'h0; priv = 2'b00; rd = 5'd0;
    csr = 12'h000; gprwe = 1'b0; csrwe = 1'b0; d1 = 64'h0; d2 = 64'h0; csr_rdy = 1'b1;
  endtask

  initial begin
    // flush, valid, itag, priv, rd, csr, gprwe, csrwe, d1, d2, csr_rdy | ready, gwe, gaddr, gdata, cwe, cdata, exc, exc_itag, cnt, err
    vecs.push_back(mk(0,0,8'h00,2'd0,5'd0,12'h000,0,0,64'h0,64'h0,1,  1,0,5'd0,64'h0,0,64'h0,0,8'h00,64'd0,0));
    vecs.push_back(mk(0,1,8'h05,2'd3,5'd3,12'h000,1,0,64'h1234,64'h0,1,  1,0,5'd0,64'h0,0,64'h0,0,8'h00,64'd0,0));
    vecs.push_back(mk(0,0,8'h00,2'd0,5'd0,12'h000,0,0,64'h0,64'h0,1,  1,1,5'd3,64'h1234,0,64'h0,0,8'h00,64'd0,0));
    vecs.push_back(mk(0,0,8'h00,2'd0,5'd0,12'h000,0,0,64'h0,64'h0,1,  1,0,5'd0,64'h0,0,64'h0,0,8'h00,64'd1,0));
    // CSR stall: head holds three cycles, ready drops after the second accept
    vecs.push_back(mk(0,1,8'h06,2'd3,5'd0,12'h300,0,1,64'h0,64'hAAAA,0,  1,0,5'd0,64'h0,0,64'h0,0,8'h00,64'd1,0));
    vecs.push_back(mk(0,1,8'h07,2'd3,5'd7,12'h000,1,0,64'h77,64'h0,0,  1,0,5'd0,64'h0,1,64'hAAAA,0,8'h00,64'd1,0));
    vecs.push_back(mk(0,1,8'h08,2'd3,5'd8,12'h000,1,0,64'h88,64'h0,0,  0,0,5'd0,64'h0,1,64'hAAAA,0,8'h00,64'd1,0));
    vecs.push_back(mk(0,1,8'h08,2'd3,5'd8,12'h000,1,0,64'h88,64'h0,0,  0,0,5'd0,64'h0,1,64'hAAAA,0,8'h00,64'd1,0));
    vecs.push_back(mk(0,1,8'h08,2'd3,5'd8,12'h000,1,0,64'h88,64'h0,1,  0,0,5'd0,64'h0,1,64'hAAAA,0,8'h00,64'd1,0));
    vecs.push_back(mk(0,1,8'h08,2'd3,5'd8,12'h000,1,0,64'h88,64'h0,1,  1,1,5'd7,64'h77,0,64'h0,0,8'h00,64'd2,0));
    vecs.push_back(mk(0,0,8'h00,2'd0,5'd0,12'h000,0,0,64'h0,64'h0,1,  1,1,5'd8,64'h88,0,64'h0,0,8'h00,64'd3,0));
    // Illegal CSR: user mode writes machine CSR 0x300
    vecs.push_back(mk(0,1,8'h09,2'd0,5'd5,12'h300,1,1,64'h55,64'hBAD,0,  1,0,5'd0,64'h0,0,64'h0,0,8'h00,64'd4,0));
    vecs.push_back(mk(0,0,8'h00,2'd0,5'd0,12'h000,0,0,64'h0,64'h0,0,  1,1,5'd5,64'h55,0,64'h0,0,8'h00,64'd4,0));
    vecs.push_back(mk(0,0,8'h00,2'd0,5'd0,12'h000,0,0,64'h0,64'h0,0,  1,0,5'd0,64'h0,0,64'h0,1,8'h09,64'd5,0));
    vecs.push_back(mk(0,0,8'h00,2'd0,5'd0,12'h000,0,0,64'h0,64'h0,1,  1,0,5'd0,64'h0,0,64'h0,0,8'h09,64'd5,0));
    // Resync, then back-to-back itags 0..3 with one write to x0
    vecs.push_back(mk(1,0,8'h00,2'd0,5'd0,12'h000,0,0,64'h0,64'h0,1,  0,0,5'd0,64'h0,0,64'h0,0,8'h09,64'd5,0));
    vecs.push_back(mk(0,1,8'h00,2'd3,5'd1,12'h000,1,0,64'h10,64'h0,1,  1,0,5'd0,64'h0,0,64'h0,0,8'h09,64'd5,0));
    vecs.push_back(mk(0,1,8'h01,2'd3,5'd0,12'h000,1,0,64'h11,64'h0,1,  1,1,5'd1,64'h10,0,64'h0,0,8'h09,64'd5,0));
    vecs.push_back(mk(0,1,8'h02,2'd3,5'd2,12'h000,1,0,64'h12,64'h0,1,  1,0,5'd0,64'h0,0,64'h0,0,8'h09,64'd6,0));
    vecs.push_back(mk(0,1,8'h03,2'd3,5'd3,12'h000,1,0,64'h13,64'h0,1,  1,1,5'd2,64'h12,0,64'h0,0,8'h09,64'd7,0));
    vecs.push_back(mk(0,0,8'h00,2'd0,5'd0,12'h000,0,0,64'h0,64'h0,1,  1,1,5'd3,64'h13,0,64'h0,0,8'h09,64'd8,0));
    vecs.push_back(mk(0,0,8'h00,2'd0,5'd0,12'h000,0,0,64'h0,64'h0,1,  1,0,5'd0,64'h0,0,64'h0,0,8'h09,64'd9,0));
    // Order error: 7 then 9, sticky across a flush and a fresh 0x20
    vecs.push_back(mk(1,0,8'h00,2'd0,5'd0,12'h000,0,0,64'h0,64'h0,1,  0,0,5'd0,64'h0,0,64'h0,0,8'h09,64'd9,0));
    vecs.push_back(mk(0,1,8'h07,2'd3,5'd1,12'h000,0,0,64'h0,64'h0,1,  1,0,5'd0,64'h0,0,64'h0,0,8'h09,64'd9,0));
    vecs.push_back(mk(0,1,8'h09,2'd3,5'd1,12'h000,0,0,64'h0,64'h0,1,  1,0,5'd0,64'h0,0,64'h0,0,8'h09,64'd9,0));
    vecs.push_back(mk(0,0,8'h00,2'd0,5'd0,12'h000,0,0,64'h0,64'h0,1,  1,0,5'd0,64'h0,0,64'h0,0,8'h09,64'd10,0));
    vecs.push_back(mk(0,0,8'h00,2'd0,5'd0,12'h000,0,0,64'h0,64'h0,1,  1,0,5'd0,64'h0,0,64'h0,0,8'h09,64'd11,1));
    vecs.push_back(mk(1,0,8'h00,2'd0,5'd0,12'h000,0,0,64'h0,64'h0,1,  0,0,5'd0,64'h0,0,64'h0,0,8'h09,64'd11,1));
    vecs.push_back(mk(0,1,8'h20,2'd3,5'd1,12'h000,0,0,64'h0,64'h0,1,  1,0,5'd0,64'h0,0,64'h0,0,8'h09,64'd11,1));
    vecs.push_back(mk(0,0,8'h00,2'd0,5'd0,12'h000,0,0,64'h0,64'h0,1,  1,0,5'd0,64'h0,0,64'h0,0,8'h09,64'd11,1));
    vecs.push_back(mk(0,0,8'h00,2'd0,5'd0,12'h000,0,0,64'h0,64'h0,1,  1,0,5'd0,64'h0,0,64'h0,0,8'h09,64'd12,1));
    // Flush with two entries buffered (head stalled on CSR): nothing written, nothing accepted
    vecs.push_back(mk(0,1,8'h21,2'd3,5'd4,12'h300,1,1,64'h44,64'hCC21,0,  1,0,5'd0,64'h0,0,64'h0,0,8'h09,64'd12,1));
    vecs.push_back(mk(0,1,8'h22,2'd3,5'd6,12'h000,1,0,64'h66,64'h0,0,  1,0,5'd0,64'h0,1,64'hCC21,0,8'h09,64'd12,1));
    vecs.push_back(mk(1,1,8'h23,2'd3,5'd9,12'h000,1,0,64'h99,64'h0,1,  0,0,5'd0,64'h0,0,64'h0,0,8'h09,64'd12,1));
    vecs.push_back(mk(0,0,8'h00,2'd0,5'd0,12'h000,0,0,64'h0,64'h0,1,  1,0,5'd0,64'h0,0,64'h0,0,8'h09,64'd12,1));
    vecs.push_back(mk(0,0,8'h00,2'd0,5'd0,12'h000,0,0,64'h0,64'h0,1,  1,0,5'd0,64'h0,0,64'h0,0,8'h09,64'd12,1));

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      flush = vecs[i].flush; valid = vecs[i].valid; itag = vecs[i].itag;
      pc = 64'h1000 + {54'h0, vecs[i].itag, 2'b00};
      priv = vecs[i].priv; rd = vecs[i].rd; csr = vecs[i].csr;
      gprwe = vecs[i].gprwe; csrwe = vecs[i].csrwe; d1 = vecs[i].d1; d2 = vecs[i].d2;
      csr_rdy = vecs[i].crdy;
      #1;
      chk($sformatf("v%0d ready", i), {63'h0, ready}, {63'h0, vecs[i].e_rdy});
      chk($sformatf("v%0d gpr_we", i), {63'h0, gpr_we}, {63'h0, vecs[i].e_gwe});
      if (vecs[i].e_gwe) begin
        chk($sformatf("v%0d gpr_addr", i), {59'h0, gpr_addr}, {59'h0, vecs[i].e_gaddr});
        chk($sformatf("v%0d gpr_data", i), gpr_data, vecs[i].e_gdata);
      end
      chk($sformatf("v%0d csr_we", i), {63'h0, csr_we}, {63'h0, vecs[i].e_cwe});
      if (vecs[i].e_cwe) begin
        chk($sformatf("v%0d csr_addr", i), {52'h0, csr_addr}, 64'h300);
        chk($sformatf("v%0d csr_data", i), csr_data, vecs[i].e_cdata);
      end
      chk($sformatf("v%0d exc_valid", i), {63'h0, exc_v}, {63'h0, vecs[i].e_exc});
      chk($sformatf("v%0d exc_itag", i), {56'h0, exc_itag}, {56'h0, vecs[i].e_eitag});
      chk($sformatf("v%0d exc_pc", i), exc_pc,
          (vecs[i].e_eitag == 8'h00) ? 64'h0 : 64'h1000 + {54'h0, vecs[i].e_eitag, 2'b00});
      chk($sformatf("v%0d retire_cnt", i), cnt, vecs[i].e_cnt);
      chk($sformatf("v%0d err_order", i), {63'h0, err}, {63'h0, vecs[i].e_err});
    end

    // Asynchronous reset in the middle of a CSR stall
    @(negedge clk);
    idle_inputs();
    valid = 1'b1; itag = 8'h40; pc = 64'h2000; priv = 2'b11; rd = 5'd12; csr = 12'h305;
    gprwe = 1'b1; csrwe = 1'b1; d1 = 64'hDEAD; d2 = 64'hBEEF; csr_rdy = 1'b0;
    @(negedge clk);
    valid = 1'b0;
    #1;
    chk("stall csr_we", {63'h0, csr_we}, 64'h1);
    chk("stall csr_data", csr_data, 64'hBEEF);
    #2;
    rst = 1'b1;
    #1;
    chk("arst csr_we", {63'h0, csr_we}, 64'h0);
    chk("arst gpr_we", {63'h0, gpr_we}, 64'h0);
    chk("arst gpr_addr", {59'h0, gpr_addr}, 64'h0);
    chk("arst gpr_data", gpr_data, 64'h0);
    chk("arst csr_addr", {52'h0, csr_addr}, 64'h0);
    chk("arst csr_data", csr_data, 64'h0);
    chk("arst ready", {63'h0, ready}, 64'h1);
    chk("arst exc_itag", {56'h0, exc_itag}, 64'h0);
    chk("arst exc_pc", exc_pc, 64'h0);
    chk("arst retire_cnt", cnt, 64'h0);
    chk("arst err_order", {63'h0, err}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    csr_rdy = 1'b1;
    @(negedge clk);
    #1;
    chk("post-arst gpr_we", {63'h0, gpr_we}, 64'h0);
    chk("post-arst csr_we", {63'h0, csr_we}, 64'h0);
    @(negedge clk);
    #1;
    chk("post-arst retire_cnt", cnt, 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
